// File: rtl/comparador_pkg.sv
// Shared types and constants for the comparator sweep engine.
// Optional macro SWEEP_ALL_EN is consumed by comparador_sweep_tx.
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int CMP_WIDTH      = 4;
    localparam int CMP_SETTLE_CYC = 2;

    // Settle counter must hold 0..SETTLE_CYC-1; keep at least one bit.
    function automatic int settle_cnt_width(input int settle_cyc);
        return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
    endfunction

endpackage

// File: rtl/comparador_sweep_tx_settle_timer.sv
// Settle timer: counts up from 0 while enabled and flags the last settle cycle.
// Holds at terminal count until cleared.
module settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    import comparador_pkg::*;

    localparam int CW = settle_cnt_width(SETTLE_CYC);
    localparam logic [CW-1:0] TC = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt;

    assign expire = (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/comparador_sweep_tx.sv
// Sweep engine that walks candidate codes into an equality comparator and records matches.
// Macro SWEEP_ALL_EN: sweep every code and count all matches instead of stopping at the first.
//
// state  | meaning
// IDLE   | waiting for start, x_out parked at 0
// SETTLE | holding current code for SETTLE_CYC cycles
// SAMPLE | registering q_in for the current code
// DONE   | one-cycle completion pulse
module comparador_sweep_tx
    import comparador_pkg::*;
#(
    parameter int WIDTH      = CMP_WIDTH,
    parameter int SETTLE_CYC = CMP_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    input  logic             q_in,
    output logic             found,
    output logic [WIDTH-1:0] match_val,
    output logic [WIDTH:0]   match_cnt
);

    localparam logic [WIDTH-1:0] LAST_CODE = '1;

    sweep_state_t state, state_nxt;

    logic settle_exp;
    logic tmr_clear;
    logic tmr_en;
    logic accept;
    logic advance;
    logic stop;

`ifdef SWEEP_ALL_EN
    assign stop = 1'b0;
`else
    assign stop = q_in;
`endif

    settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expire (settle_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    tmr_clear = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                busy   = 1'b1;
                tmr_en = 1'b1;
                if (settle_exp) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (stop || (x_out == LAST_CODE)) begin
                    state_nxt = DONE;
                end else begin
                    advance   = 1'b1;
                    tmr_clear = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results stay valid through DONE and IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_out     <= '0;
            found     <= 1'b0;
            match_val <= '0;
            match_cnt <= '0;
        end else if (accept) begin
            x_out     <= '0;
            found     <= 1'b0;
            match_val <= '0;
            match_cnt <= '0;
        end else if (state == SAMPLE) begin
            if (q_in && !found) begin
                found     <= 1'b1;
                match_val <= x_out;
            end
`ifdef SWEEP_ALL_EN
            if (q_in) begin
                match_cnt <= match_cnt + 1'b1;
            end
`else
            if (q_in && !found) begin
                match_cnt <= {{WIDTH{1'b0}}, 1'b1};
            end
`endif
            if (advance) begin
                x_out <= x_out + 1'b1;
            end
        end else if (state == DONE) begin
            x_out <= '0;
        end
    end

endmodule
